// File: rtl/reg_writeback_queue_if.sv
// rtl/reg_writeback_queue_if.sv - result/write-port bundle for the writeback queue; bypass signals under WB_BYPASS_EN
interface reg_writeback_queue_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_data;
  logic              flush;
  logic              wr_hold;
  logic              write_reg;
  logic [ADDR_W-1:0] write_reg_addr;
  logic [DATA_W-1:0] write_reg_data;
  logic [31:0]       busy_mask;
  logic              pending;
`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0] byp_addr1;
  logic [ADDR_W-1:0] byp_addr2;
  logic              byp_hit1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data1;
  logic [DATA_W-1:0] byp_data2;

  // Queue side: consumes results, masters the register file write port.
  modport master (
    input  res_valid, res_addr, res_data, flush, wr_hold, byp_addr1, byp_addr2,
    output res_ready, write_reg, write_reg_addr, write_reg_data, busy_mask, pending,
           byp_hit1, byp_hit2, byp_data1, byp_data2
  );

  // Environment side: producer, hazard logic and register file.
  modport slave (
    output res_valid, res_addr, res_data, flush, wr_hold, byp_addr1, byp_addr2,
    input  res_ready, write_reg, write_reg_addr, write_reg_data, busy_mask, pending,
           byp_hit1, byp_hit2, byp_data1, byp_data2
  );
`else
  // Queue side: consumes results, masters the register file write port.
  modport master (
    input  res_valid, res_addr, res_data, flush, wr_hold,
    output res_ready, write_reg, write_reg_addr, write_reg_data, busy_mask, pending
  );

  // Environment side: producer, hazard logic and register file.
  modport slave (
    output res_valid, res_addr, res_data, flush, wr_hold,
    input  res_ready, write_reg, write_reg_addr, write_reg_data, busy_mask, pending
  );
`endif
endinterface

// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - in-order writeback FIFO driving the register file write port; forwarding under WB_BYPASS_EN
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  reg_writeback_queue_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] entry_addr [DEPTH];
  logic [DATA_W-1:0] entry_data [DEPTH];
  logic [DEPTH-1:0]  entry_valid;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic is_empty;
  logic is_full;
  logic accept;
  logic enqueue;
  logic pop;
  logic [31:0] busy;

  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_W'(DEPTH));

  // A flush cycle refuses offers so nothing slips in behind the discard.
  assign bus.res_ready = !is_full && !bus.flush;
  assign accept        = bus.res_valid && bus.res_ready;
  // Writes to x0 complete the handshake but never occupy a slot.
  assign enqueue       = accept && (bus.res_addr != '0);
  assign pop           = !is_empty && !bus.wr_hold;

  assign bus.pending        = !is_empty;
  assign bus.write_reg      = pop;
  assign bus.write_reg_addr = is_empty ? '0 : entry_addr[rd_ptr];
  assign bus.write_reg_data = is_empty ? '0 : entry_data[rd_ptr];
  assign bus.busy_mask      = busy;

  // Queue control: pointers, occupancy and per-slot valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else if (bus.flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      // Slots only coincide when empty or full, and those exclude pop or enqueue.
      if (pop) begin
        entry_valid[rd_ptr] <= 1'b0;
        rd_ptr              <= rd_ptr + PTR_W'(1);
      end
      if (enqueue) begin
        entry_valid[wr_ptr] <= 1'b1;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      if (enqueue && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !enqueue) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Payload storage; left unreset because entry_valid and count gate every use.
  always_ff @(posedge clk) begin
    if (enqueue) begin
      entry_addr[wr_ptr] <= bus.res_addr;
      entry_data[wr_ptr] <= bus.res_data;
    end
  end

  // Pending-destination mask: one bit per register targeted by a live entry.
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        for (int b = 1; b < 32; b++) begin
          if (32'(entry_addr[i]) == 32'(b)) begin
            busy[b] = 1'b1;
          end
        end
      end
    end
  end

`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0] byp_addr [2];
  logic              byp_hit  [2];
  logic [DATA_W-1:0] byp_data [2];

  assign byp_addr[0]   = bus.byp_addr1;
  assign byp_addr[1]   = bus.byp_addr2;
  assign bus.byp_hit1  = byp_hit[0];
  assign bus.byp_hit2  = byp_hit[1];
  assign bus.byp_data1 = byp_data[0];
  assign bus.byp_data2 = byp_data[1];

  // Forwarding: scan oldest to youngest so the youngest match wins; head still counts.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      byp_hit[p]  = 1'b0;
      byp_data[p] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + PTR_W'(k);
        if (entry_valid[idx] && (byp_addr[p] != '0) && (entry_addr[idx] == byp_addr[p])) begin
          byp_hit[p]  = 1'b1;
          byp_data[p] = entry_data[idx];
        end
      end
    end
  end
`endif

endmodule
